// File: rtl/encode6_3_sync_pkg.sv
// Shared constants for the 6-to-3 one-hot encoder: FSM state codes,
// the six legal one-hot codes and their element indices.
package encode6_3_sync_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SETTLE = 2'b01;
    localparam logic [1:0] ST_LOCKED = 2'b10;
    localparam logic [1:0] ST_FAULT  = 2'b11;

    localparam logic [5:0] CODE_0 = 6'b000001;
    localparam logic [5:0] CODE_1 = 6'b000010;
    localparam logic [5:0] CODE_2 = 6'b000100;
    localparam logic [5:0] CODE_3 = 6'b001000;
    localparam logic [5:0] CODE_4 = 6'b010000;
    localparam logic [5:0] CODE_5 = 6'b100000;

    localparam logic [2:0] IDX_0 = 3'd0;
    localparam logic [2:0] IDX_1 = 3'd1;
    localparam logic [2:0] IDX_2 = 3'd2;
    localparam logic [2:0] IDX_3 = 3'd3;
    localparam logic [2:0] IDX_4 = 3'd4;
    localparam logic [2:0] IDX_5 = 3'd5;

endpackage

// File: rtl/encode6_3_sync_if.sv
// Bus bundle between the encoder and whatever drives it: select lines and
// controls in, registered index / status / error count out.
interface encode6_3_sync_if #(
    parameter int ERR_W = 8
) ();
    logic             en;
    logic [5:0]       DataIn;
    logic             clr_err;
    logic [2:0]       s;
    logic             valid;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output en, DataIn, clr_err,
        input  s, valid, err_pulse, err_cnt
    );

    modport slave (
        input  en, DataIn, clr_err,
        output s, valid, err_pulse, err_cnt
    );
endinterface

// File: rtl/encode6_3_sync_core.sv
// Pure combinational classifier for a 6-bit select word: element index
// of a one-hot code plus one-hot / all-zero flags.
module enc6_3_core
    import encode6_3_sync_pkg::*;
(
    input  logic [5:0] code,
    output logic [2:0] idx,
    output logic       is_onehot,
    output logic       is_zero
);

    // Index is only meaningful when is_onehot is set; anything else reads as 0.
    always_comb begin
        idx       = IDX_0;
        is_onehot = 1'b1;
        case (code)
            CODE_0:  idx = IDX_0;
            CODE_1:  idx = IDX_1;
            CODE_2:  idx = IDX_2;
            CODE_3:  idx = IDX_3;
            CODE_4:  idx = IDX_4;
            CODE_5:  idx = IDX_5;
            default: is_onehot = 1'b0;
        endcase
        is_zero = (code == 6'b000000);
    end

endmodule

// File: rtl/encode6_3_sync.sv
// Debounced 6-to-3 one-hot encoder: a code must be seen unchanged for
// STABLE_CNT samples before it is published; stable multi-hot codes are counted as errors.
module encode6_3_sync
    import encode6_3_sync_pkg::*;
#(
    parameter int STABLE_CNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    encode6_3_sync_if.slave   bus
);

    logic [1:0]       state_q,     state_d;
    logic [5:0]       d_q,         d_d;
    logic [3:0]       stab_q,      stab_d;
    logic [2:0]       s_q,         s_d;
    logic             valid_q,     valid_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_cnt_q,   err_cnt_d;

    logic [2:0]       core_idx;
    logic             core_onehot;
    logic             core_zero;
    logic [4:0]       stab_inc;

    enc6_3_core u_core (
        .code      (d_q),
        .idx       (core_idx),
        .is_onehot (core_onehot),
        .is_zero   (core_zero)
    );

    assign stab_inc = {1'b0, stab_q} + 5'd1;

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        stab_d      = stab_q;
        s_d         = s_q;
        valid_d     = valid_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (!bus.en) begin
            state_d = ST_IDLE;
            d_d     = 6'b000000;
            stab_d  = 4'd0;
            s_d     = 3'd0;
            valid_d = 1'b0;
        end else if (bus.DataIn != d_q) begin
            // Any change restarts the settle window; s keeps its last value.
            state_d = ST_SETTLE;
            d_d     = bus.DataIn;
            stab_d  = 4'd1;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SETTLE;
                    stab_d  = 4'd1;
                end
                ST_SETTLE: begin
                    if (stab_inc < 5'(STABLE_CNT)) begin
                        stab_d = stab_inc[3:0];
                    end else if (core_onehot) begin
                        state_d = ST_LOCKED;
                        s_d     = core_idx;
                        valid_d = 1'b1;
                    end else if (!core_zero) begin
                        state_d     = ST_FAULT;
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                    end else begin
                        // All-zero input never resolves; park the counter.
                        stab_d  = 4'(STABLE_CNT);
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    // LOCKED and FAULT hold until the input changes.
                end
            endcase
        end

        if (bus.clr_err) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            d_q         <= 6'b000000;
            stab_q      <= 4'd0;
            s_q         <= 3'd0;
            valid_q     <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            stab_q      <= stab_d;
            s_q         <= s_d;
            valid_q     <= valid_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.s         = s_q;
    assign bus.valid     = valid_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule
